// File: rtl/riscv_pkg.sv
// Shared RISC-V CSR types: operand width, CSR op encoding and the mstatus field layout,
// plus the architectural trap-entry / MRET field updates used by the CSR controller.
package riscv_pkg;

   localparam int          XLEN             = 32;
   localparam logic [11:0] CSR_MSTATUS_ADDR = 12'h300;

   // Encoding follows funct3[1:0] of the CSR instructions
   typedef enum logic [1:0] {
      CSR_RW = 2'b01,
      CSR_RS = 2'b10,
      CSR_RC = 2'b11
   } riscv_csr_op_t;

   typedef struct packed {
      logic [18:0] rsvd_31_13;
      logic [1:0]  mpp;
      logic [2:0]  rsvd_10_8;
      logic        mpie;
      logic [2:0]  rsvd_6_4;
      logic        mie;
      logic [2:0]  rsvd_2_0;
   } riscv_mstatus_t;

   function automatic riscv_mstatus_t mstatus_trap(input riscv_mstatus_t cur);
      riscv_mstatus_t nxt;
      nxt      = cur;
      nxt.mpie = cur.mie;
      nxt.mie  = 1'b0;
      nxt.mpp  = 2'b11;
      return nxt;
   endfunction

   // Only M-mode exists, so MPP is pinned back to M on return
   function automatic riscv_mstatus_t mstatus_mret(input riscv_mstatus_t cur);
      riscv_mstatus_t nxt;
      nxt      = cur;
      nxt.mie  = cur.mpie;
      nxt.mpie = 1'b1;
      nxt.mpp  = 2'b11;
      return nxt;
   endfunction

endpackage

// File: rtl/riscv_csr_ctrl.sv
// CSR instruction controller for mstatus: IDLE/EXEC/RESP request pipeline with a
// read-modify-write port to riscv_csr and arbitration of trap-entry and MRET updates.
module riscv_csr_ctrl
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_1888
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  riscv_csr_op_t   req_op,
   input  logic [11:0]     req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_illegal,
   input  logic            trap_i,
   input  logic            mret_i,
   input  riscv_mstatus_t  mstatus_rd,
   output riscv_mstatus_t  mstatus_data_in,
   output logic            mstatus_wr_en
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_r, state_s;
   riscv_csr_op_t   op_r;
   logic [11:0]     addr_r;
   logic [XLEN-1:0] wdata_r;
   logic            trap_pend_r, mret_pend_r;
   logic            rsp_valid_r, rsp_illegal_r;
   logic [XLEN-1:0] rsp_rdata_r;

   logic            req_ready_s, accept_s, trap_now_s, mret_now_s;
   logic            legal_s, csr_we_s;
   logic [XLEN-1:0] old_s, new_s, merged_s;

   // Handshake gating: pending or live trap/mret owns the IDLE cycle
   always_comb begin
      trap_now_s  = (state_r == IDLE) && (trap_i || trap_pend_r);
      mret_now_s  = (state_r == IDLE) && !trap_now_s && (mret_i || mret_pend_r);
      req_ready_s = (state_r == IDLE) && !trap_i && !mret_i && !trap_pend_r && !mret_pend_r;
      accept_s    = req_valid && req_ready_s;
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = EXEC;
            else          state_s = IDLE;
         end
         EXEC:    state_s = RESP;
         RESP: begin
            if (rsp_ready) state_s = IDLE;
            else           state_s = RESP;
         end
         default: state_s = IDLE;
      endcase
   end

   // CSR read-modify-write value and write qualification
   always_comb begin
      old_s    = mstatus_rd;
      legal_s  = (addr_r == CSR_MSTATUS_ADDR);
      new_s    = old_s;
      csr_we_s = 1'b0;
      case (op_r)
         CSR_RW: begin
            new_s    = wdata_r;
            csr_we_s = 1'b1;
         end
         CSR_RS: begin
            new_s    = old_s | wdata_r;
            csr_we_s = (wdata_r != {XLEN{1'b0}});
         end
         CSR_RC: begin
            new_s    = old_s & ~wdata_r;
            csr_we_s = (wdata_r != {XLEN{1'b0}});
         end
         default: begin
            new_s    = old_s;
            csr_we_s = 1'b0;
         end
      endcase
      merged_s = (old_s & ~MSTATUS_WMASK) | (new_s & MSTATUS_WMASK);
   end

   // Single mstatus write port; trap beats mret, and reset suppresses any write
   always_comb begin
      mstatus_wr_en   = 1'b0;
      mstatus_data_in = '0;
      if (rst) begin
         mstatus_wr_en = 1'b0;
      end else if (trap_now_s) begin
         mstatus_wr_en   = 1'b1;
         mstatus_data_in = mstatus_trap(mstatus_rd);
      end else if (mret_now_s) begin
         mstatus_wr_en   = 1'b1;
         mstatus_data_in = mstatus_mret(mstatus_rd);
      end else if ((state_r == EXEC) && legal_s && csr_we_s) begin
         mstatus_wr_en   = 1'b1;
         mstatus_data_in = riscv_mstatus_t'(merged_s);
      end else begin
         mstatus_wr_en = 1'b0;
      end
   end

   // State register and request capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         op_r    <= CSR_RW;
         addr_r  <= 12'h000;
         wdata_r <= {XLEN{1'b0}};
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            op_r    <= req_op;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
         end
      end
   end

   // Trap/mret arriving while busy is parked until the next IDLE cycle consumes it
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_pend_r <= 1'b0;
         mret_pend_r <= 1'b0;
      end else if (state_r == IDLE) begin
         trap_pend_r <= 1'b0;
         mret_pend_r <= 1'b0;
      end else begin
         trap_pend_r <= trap_pend_r | trap_i;
         mret_pend_r <= mret_pend_r | mret_i;
      end
   end

   // Response registers, held stable while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= {XLEN{1'b0}};
         rsp_illegal_r <= 1'b0;
      end else if (state_r == EXEC) begin
         rsp_valid_r   <= 1'b1;
         rsp_rdata_r   <= legal_s ? old_s : {XLEN{1'b0}};
         rsp_illegal_r <= !legal_s;
      end else if ((state_r == RESP) && rsp_ready) begin
         rsp_valid_r <= 1'b0;
      end
   end

   assign req_ready   = req_ready_s;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_rdata   = rsp_rdata_r;
   assign rsp_illegal = rsp_illegal_r;

endmodule
